seg_pattern_decoder: RTL
========================

SEG_PATTERN_DECODER -- requirements
Module: seg_pattern_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive identical synchronized samples required to accept a pattern (legal range 1..15).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 seg_in  input  7  segment pattern, bit0=a .. bit6=g, active-high, asynchronous to clk.
REQ-005 sym_out  output  4  decoded symbol index 0..12.
REQ-006 sym_valid  output  1  sym_out holds an undelivered symbol.
REQ-007 sym_ready  input  1  consumer accepts symbol when sym_valid&&sym_ready.
REQ-008 dir_fwd  output  1  direction of last step: 1=forward (index+1), 0=backward (index-1).
REQ-009 dir_valid  output  1  dir_fwd reflects a legal adjacent step.
REQ-010 bad_pat  output  1  one-cycle pulse: accepted non-blank pattern not in table.
REQ-011 skip_err  output  1  one-cycle pulse: accepted symbol not adjacent (mod 13) to previous symbol.
REQ-012 ovf  output  1  sticky: a symbol was dropped because sym_valid was still pending.

Function
REQ-013 seg_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Stability filter SHALL count consecutive cycles with unchanged synchronized pattern; pattern is "accepted" on the cycle the count reaches STABLE_CYCLES, and only once per distinct pattern.
REQ-015 Symbol table (index:hex gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F 10:77 11:7C 12:39.
REQ-016 Accepted pattern 0x00 = blank: no symbol, no error, direction history cleared (state -> NO_HIST), dir_valid=0.
REQ-017 Accepted pattern not in table and not blank: bad_pat pulses, history cleared, no symbol emitted.
REQ-018 Accepted table pattern: symbol loaded into output register with sym_valid=1 on the cycle after acceptance; latency seg_in change -> sym_valid = STABLE_CYCLES+3 cycles (7 at default).
REQ-019 sym_valid SHALL remain high with sym_out stable until the cycle sym_ready is sampled high; then deasserts next cycle unless a new symbol loads that same cycle (new symbol wins, sym_valid stays 1).
REQ-020 New symbol while sym_valid=1 and sym_ready=0: new symbol dropped, ovf set, direction tracking still updated.
REQ-021 State machine NO_HIST/TRACK: NO_HIST + symbol -> TRACK, dir_valid=0; TRACK + symbol s with prev p: s==(p+1)%13 -> dir_fwd=1, dir_valid=1; s==(p+12)%13 -> dir_fwd=0, dir_valid=1; else skip_err pulse, dir_valid=0, stay TRACK with p=s.
REQ-022 Wrap-around: 12->0 is forward, 0->12 is backward.
REQ-023 Pattern changing before count completes restarts the count; glitches shorter than STABLE_CYCLES SHALL produce no output activity.
REQ-024 Re-accepting same pattern after blank in between counts as a new symbol.

Reset
REQ-025 While rst=1: synchronizer, filter count, last-accepted pattern cleared to 0x00; state NO_HIST; sym_out=0, sym_valid=0, dir_fwd=0, dir_valid=0, bad_pat=0, skip_err=0, ovf=0.
REQ-026 Reset asserted mid-handshake SHALL discard the pending symbol; after release first accepted symbol behaves as from NO_HIST.

Structure
REQ-027 Package seg_pattern_pkg SHALL hold NUM_SYMS=13, SEG_BLANK=7'h00, SEG_TABLE constant array, symbol index type (4 bits), state enum.
REQ-028 One sub-module seg_stable_filter (synchronizer + stability counter, outputs accepted pattern + accept strobe).
REQ-029 Table lookup SHALL be combinational priority-free match over SEG_TABLE.

Verification
REQ-030 Reset release, seg_in=0x3F held, sym_ready=1 -> sym_valid high exactly 7 cycles after change, sym_out=0, dir_valid=0.
REQ-031 Sequence 0x39,0x3F,0x06 each held 10 cycles -> sym_out 12,0,1; dir_fwd=1, dir_valid=1 on 2nd and 3rd.
REQ-032 Sequence 0x06,0x3F,0x39 -> dir_fwd=0 dir_valid=1; then 0x7F -> skip_err one pulse, dir_valid=0.
REQ-033 seg_in=0x49 held 10 cycles -> bad_pat one pulse, sym_valid stays 0; 3-cycle 0x06 glitch -> no activity.
REQ-034 sym_ready=0, symbols 0x3F then 0x06 -> sym_out stays 0, ovf=1; sym_ready=1 -> sym_valid drops next cycle.
REQ-035 rst pulsed while sym_valid=1 -> all outputs 0 immediately (async), ovf cleared.

Source files
------------

// File: rtl/seg_pattern_pkg.sv
// Shared constants, types and helpers for the seven-segment pattern decoder.
package seg_pattern_pkg;

  localparam int NUM_SYMS = 13;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index i holds the gfedcba pattern for symbol i.
  localparam logic [6:0] SEG_TABLE [NUM_SYMS] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
    7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39
  };

  typedef logic [3:0] sym_idx_t;

  typedef enum logic {
    ST_NO_HIST = 1'b0,
    ST_TRACK   = 1'b1
  } state_t;

  function automatic sym_idx_t sym_inc(input sym_idx_t s);
    return (s == sym_idx_t'(NUM_SYMS - 1)) ? sym_idx_t'(0) : sym_idx_t'(s + 4'd1);
  endfunction

  function automatic sym_idx_t sym_dec(input sym_idx_t s);
    return (s == sym_idx_t'(0)) ? sym_idx_t'(NUM_SYMS - 1) : sym_idx_t'(s - 4'd1);
  endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Two-flop synchronizer plus stability counter; strobes once per newly
// settled pattern that differs from the last one accepted.
module seg_stable_filter
  import seg_pattern_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_seg,
  output logic [6:0] o_pat,
  output logic       o_accept
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  logic [6:0] r_sync1;
  logic [6:0] r_sync2;
  logic [6:0] r_cand;
  logic [6:0] r_last;
  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= SEG_BLANK;
      r_sync2 <= SEG_BLANK;
      r_cand  <= SEG_BLANK;
      r_last  <= SEG_BLANK;
      r_cnt   <= 4'd0;
    end else begin
      r_sync1 <= i_seg;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= 4'd1;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (o_accept) r_last <= r_cand;
    end
  end

  // Comparing against the last accepted pattern suppresses glitches that
  // return to the previously settled value.
  assign o_accept = (r_cnt == CNT_MAX) && (r_cand != r_last);
  assign o_pat    = r_cand;

endmodule

// File: rtl/seg_pattern_decoder.sv
// Decodes settled seven-segment patterns into symbol indices with a
// valid/ready output, step-direction tracking and error flags.
module seg_pattern_decoder
  import seg_pattern_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       dir_fwd,
  output logic       dir_valid,
  output logic       bad_pat,
  output logic       skip_err,
  output logic       ovf
);

  logic [6:0] w_pat;
  logic       w_accept;
  logic       w_hit;
  sym_idx_t   w_idx;

  state_t   r_state, w_state_next;
  sym_idx_t r_prev, w_prev_next;
  sym_idx_t r_sym_out, w_sym_out_next;
  logic     r_sym_valid, w_sym_valid_next;
  logic     r_dir_fwd, w_dir_fwd_next;
  logic     r_dir_valid, w_dir_valid_next;
  logic     r_bad_pat, w_bad_pat_next;
  logic     r_skip_err, w_skip_err_next;
  logic     r_ovf, w_ovf_next;

  seg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .i_seg   (seg_in),
    .o_pat   (w_pat),
    .o_accept(w_accept)
  );

  // Table entries are unique, so OR-ing matching indices needs no priority.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = 0; i < NUM_SYMS; i++) begin
      if (w_pat == SEG_TABLE[i]) begin
        w_hit = 1'b1;
        w_idx = w_idx | sym_idx_t'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_NO_HIST;
      r_prev      <= '0;
      r_sym_out   <= '0;
      r_sym_valid <= 1'b0;
      r_dir_fwd   <= 1'b0;
      r_dir_valid <= 1'b0;
      r_bad_pat   <= 1'b0;
      r_skip_err  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_prev      <= w_prev_next;
      r_sym_out   <= w_sym_out_next;
      r_sym_valid <= w_sym_valid_next;
      r_dir_fwd   <= w_dir_fwd_next;
      r_dir_valid <= w_dir_valid_next;
      r_bad_pat   <= w_bad_pat_next;
      r_skip_err  <= w_skip_err_next;
      r_ovf       <= w_ovf_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_prev_next      = r_prev;
    w_sym_out_next   = r_sym_out;
    w_sym_valid_next = r_sym_valid;
    w_dir_fwd_next   = r_dir_fwd;
    w_dir_valid_next = r_dir_valid;
    w_bad_pat_next   = 1'b0;
    w_skip_err_next  = 1'b0;
    w_ovf_next       = r_ovf;

    if (r_sym_valid && sym_ready) w_sym_valid_next = 1'b0;

    if (w_accept) begin
      if (w_pat == SEG_BLANK) begin
        w_state_next     = ST_NO_HIST;
        w_dir_valid_next = 1'b0;
      end else if (!w_hit) begin
        w_bad_pat_next   = 1'b1;
        w_state_next     = ST_NO_HIST;
        w_dir_valid_next = 1'b0;
      end else begin
        // A consumer handshake in this same cycle frees the slot for the new symbol.
        if (!r_sym_valid || sym_ready) begin
          w_sym_out_next   = w_idx;
          w_sym_valid_next = 1'b1;
        end else begin
          w_ovf_next = 1'b1;
        end
        w_prev_next = w_idx;
        if (r_state == ST_NO_HIST) begin
          w_state_next     = ST_TRACK;
          w_dir_valid_next = 1'b0;
        end else if (w_idx == sym_inc(r_prev)) begin
          w_dir_fwd_next   = 1'b1;
          w_dir_valid_next = 1'b1;
        end else if (w_idx == sym_dec(r_prev)) begin
          w_dir_fwd_next   = 1'b0;
          w_dir_valid_next = 1'b1;
        end else begin
          w_skip_err_next  = 1'b1;
          w_dir_valid_next = 1'b0;
        end
      end
    end
  end

  assign sym_out   = r_sym_out;
  assign sym_valid = r_sym_valid;
  assign dir_fwd   = r_dir_fwd;
  assign dir_valid = r_dir_valid;
  assign bad_pat   = r_bad_pat;
  assign skip_err  = r_skip_err;
  assign ovf       = r_ovf;

endmodule
